row_store: RTL and testbench
============================

ROW_STORE -- requirements
Module: row_store

Interface
REQ-001 Parameter: ROWS, 75, number of stored generations (rows); valid addresses 0..ROWS-1.
REQ-002 Parameter: COLS, 100, cells per row; valid columns 0..COLS-1.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_in  input  COLS  row from upstream generator; bit 0 = leftmost cell (column 0).
REQ-006 addr_in  input  7  row index of data_in.
REQ-007 vblank  input  1  display not reading memory; writes permitted only while high.
REQ-008 rd_row  input  7  display read row.
REQ-009 rd_col  input  7  display read column.
REQ-010 rd_pixel  output  1  cell value at (rd_row, rd_col), registered.
REQ-011 init_rdy  output  1  memory clear complete.
REQ-012 rdy  output  1  store can accept a new row; drives upstream rdy.
REQ-013 ovf_err  output  1  sticky error: row dropped or address out of range.

Function
REQ-014 Storage SHALL be ROWS x COLS bits, one write port (full row) and one read port (single bit).
REQ-015 FSM states SHALL be CLEAR, IDLE, PENDING; reset enters CLEAR.
REQ-016 CLEAR: a clear counter SHALL write all-zero to row 0, 1, ... ROWS-1, one row per cycle, ignoring vblank; after row ROWS-1 is written, next state IDLE and init_rdy SHALL rise the following cycle, held high until reset.
REQ-017 A last_addr register SHALL reset to 7'h7F (never a valid row).
REQ-018 IDLE: when addr_in != last_addr and addr_in < ROWS, the block SHALL latch data_in and addr_in into hold registers, set last_addr <= addr_in, and enter PENDING.
REQ-019 IDLE: when addr_in != last_addr and addr_in >= ROWS, the block SHALL set last_addr <= addr_in, set ovf_err, write nothing, remain IDLE.
REQ-020 Wrap-around ROWS-1 -> 0 SHALL be treated as any other address change (captured).
REQ-021 PENDING: on the first cycle with vblank high, hold data SHALL be written to mem[hold_addr] and state SHALL return to IDLE the next cycle.
REQ-022 PENDING: an addr_in change SHALL update last_addr, drop the new row, set ovf_err; the held row is still written.
REQ-023 No address comparison or capture SHALL occur in CLEAR; the first comparison happens in the first IDLE cycle (so row 0 present at reset is captured then).
REQ-024 rdy SHALL equal (state == IDLE) && init_rdy, registered; rdy is low from reset until CLEAR finishes and for every cycle in PENDING.
REQ-025 Capture-to-write latency SHALL be 1 cycle minimum when vblank is already high (capture at edge N, write at edge N+1).
REQ-026 rd_pixel SHALL be mem[rd_row][rd_col] registered, 1-cycle latency; rd_row >= ROWS or rd_col >= COLS SHALL yield 0.
REQ-027 Read and write of the same row in the same cycle SHALL return the pre-write value (read-before-write).
REQ-028 During CLEAR rd_pixel SHALL read 0 for every cleared row and is otherwise don't-care until init_rdy.

Reset
REQ-029 Reset values: rd_pixel=0, init_rdy=0, rdy=0, ovf_err=0, state=CLEAR, clear counter=0, last_addr=7'h7F, hold registers=0.
REQ-030 Reset asserted mid-PENDING or mid-CLEAR SHALL abandon the operation (no write of held row) and restart CLEAR from row 0.
REQ-031 ovf_err SHALL clear only on reset.

Verification
REQ-032 Reset, addr_in=0, data_in bit 50 set, vblank=0 -> init_rdy high after 75 clear writes + 1 cycle, rdy stays 0 (PENDING); raise vblank -> row 0 written, rdy=1 next cycle, rd_row=0,rd_col=50 -> rd_pixel=1 one cycle later, col 49 -> 0.
REQ-033 Step addr_in 0..74 then 0 with vblank=1, new data each step -> every row readable with its data; wrap to 0 overwrites row 0; ovf_err stays 0.
REQ-034 addr_in=80 in IDLE -> no write, ovf_err=1, rdy stays 1.
REQ-035 In PENDING with vblank=0, change addr_in 3->4 -> row 3 written when vblank rises, row 4 not written, ovf_err=1.
REQ-036 Reset asserted 10 cycles into CLEAR after a prior fill -> all 75 rows read 0 after init_rdy; rd_row=75 or rd_col=100 -> rd_pixel=0.

Source files
------------

// File: rtl/row_store.sv
// Row-organised cell store between a generation producer and a display scanner.
// Full-row writes are deferred to vertical blank; single-bit reads are registered.
module row_store #(
  parameter int ROWS = 75,
  parameter int COLS = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] data_in,
  input  logic [6:0]      addr_in,
  input  logic            vblank,
  input  logic [6:0]      rd_row,
  input  logic [6:0]      rd_col,
  output logic            rd_pixel,
  output logic            init_rdy,
  output logic            rdy,
  output logic            ovf_err
);

  localparam logic [6:0] ROWS_W   = 7'(ROWS);
  localparam logic [6:0] COLS_W   = 7'(COLS);
  localparam logic [6:0] LAST_ROW = 7'(ROWS - 1);
  localparam logic [6:0] NO_ROW   = 7'h7F;

  typedef enum logic [1:0] {CLEAR, IDLE, PENDING} state_t;

  state_t          state, state_nx;
  logic [COLS-1:0] mem [ROWS];
  logic [6:0]      clr_cnt;
  logic [6:0]      last_addr, last_addr_nx;
  logic [6:0]      hold_addr, hold_addr_nx;
  logic [COLS-1:0] hold_data, hold_data_nx;
  logic            we, mem_we, ovf_set, addr_new;
  logic [6:0]      waddr;
  logic [COLS-1:0] wdata;

  assign addr_new = (addr_in != last_addr);
  assign mem_we   = we && !rst;

  always_comb begin
    state_nx     = state;
    last_addr_nx = last_addr;
    hold_addr_nx = hold_addr;
    hold_data_nx = hold_data;
    we           = 1'b0;
    waddr        = hold_addr;
    wdata        = hold_data;
    ovf_set      = 1'b0;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_cnt;
        wdata = '0;
        if (clr_cnt == LAST_ROW) state_nx = IDLE;
        else                     state_nx = CLEAR;
      end
      IDLE: begin
        if (addr_new) begin
          last_addr_nx = addr_in;
          if (addr_in < ROWS_W) begin
            hold_addr_nx = addr_in;
            hold_data_nx = data_in;
            state_nx     = PENDING;
          end else begin
            ovf_set = 1'b1;
          end
        end
      end
      PENDING: begin
        if (vblank) begin
          we       = 1'b1;
          state_nx = IDLE;
        end
        // The held row still goes out; any newer row arriving now is lost.
        if (addr_new) begin
          last_addr_nx = addr_in;
          ovf_set      = 1'b1;
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= 7'd0;
      last_addr <= NO_ROW;
      hold_addr <= 7'd0;
      hold_data <= '0;
      init_rdy  <= 1'b0;
      rdy       <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      if (state == CLEAR && clr_cnt != LAST_ROW) clr_cnt <= clr_cnt + 7'd1;
      last_addr <= last_addr_nx;
      hold_addr <= hold_addr_nx;
      hold_data <= hold_data_nx;
      init_rdy  <= init_rdy | (state != CLEAR);
      rdy       <= (state_nx == IDLE) && (init_rdy || state != CLEAR);
      ovf_err   <= ovf_err | ovf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr] <= wdata;
  end

  // Non-blocking read alongside the write gives read-before-write on a row collision.
  always_ff @(posedge clk) begin
    if (rst)
      rd_pixel <= 1'b0;
    else if (rd_row < ROWS_W && rd_col < COLS_W)
      rd_pixel <= mem[rd_row][rd_col];
    else
      rd_pixel <= 1'b0;
  end

endmodule

// File: tb/tb_row_store.sv
// Directed/random bench for row_store; a row-array model tracks expected contents.
module tb_row_store;

  localparam int ROWS = 75;
  localparam int COLS = 100;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [COLS-1:0] data_in = '0;
  logic [6:0]      addr_in = 7'd0;
  logic            vblank = 1'b0;
  logic [6:0]      rd_row = 7'd0;
  logic [6:0]      rd_col = 7'd0;
  logic            rd_pixel, init_rdy, rdy, ovf_err;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: plain array of rows plus sticky error and last seen address.
  logic [COLS-1:0] mem_m [ROWS];
  logic            ovf_m;
  int              last_m;

  row_store #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .addr_in(addr_in), .vblank(vblank),
    .rd_row(rd_row), .rd_col(rd_col), .rd_pixel(rd_pixel), .init_rdy(init_rdy),
    .rdy(rdy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [COLS-1:0] rnd_row();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[COLS-1:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ROWS; i++) mem_m[i] = '0;
    ovf_m  = 1'b0;
    last_m = 127;
  endtask

  task automatic read_chk(input string tag, input int row, input int col, input logic exp);
    rd_row = 7'(row);
    rd_col = 7'(col);
    step();
    check(tag, 32'(rd_pixel), 32'(exp));
  endtask

  task automatic read_model(input string tag, input int row, input int col);
    logic [COLS-1:0] r;
    r = mem_m[row];
    read_chk(tag, row, col, r[col]);
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (rdy !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check(tag, 32'(rdy), 32'd1);
  endtask

  // Counts cycles from reset release to init_rdy; bounded.
  task automatic release_and_init(output int cycles);
    rst = 1'b0;
    cycles = 0;
    while (init_rdy !== 1'b1 && cycles < 200) begin
      step();
      cycles++;
    end
  endtask

  // Offer one row with vblank high; model applies the address-change rules.
  task automatic put_row(input int a, input logic [COLS-1:0] d);
    wait_rdy("rdy_before_put");
    addr_in = 7'(a);
    data_in = d;
    step();
    if (a != last_m) begin
      last_m = a;
      if (a < ROWS) mem_m[a] = d;
      else          ovf_m = 1'b1;
    end
  endtask

  initial begin
    int cyc;
    logic [COLS-1:0] d, d3, d4;

    model_reset();
    d = '0;
    d[50] = 1'b1;
    data_in = d;
    repeat (3) step();
    check("reset_init_rdy", 32'(init_rdy), 32'd0);
    check("reset_rdy", 32'(rdy), 32'd0);
    check("reset_ovf", 32'(ovf_err), 32'd0);
    check("reset_pixel", 32'(rd_pixel), 32'd0);

    // Row 0 present at reset is captured in the first IDLE cycle, then waits for vblank.
    release_and_init(cyc);
    check("init_latency", 32'(cyc), 32'd76);
    for (int i = 0; i < 5; i++) begin
      check("rdy_low_pending", 32'(rdy), 32'd0);
      step();
    end
    last_m = 0;
    mem_m[0] = d;
    vblank = 1'b1;
    step();
    check("rdy_after_write", 32'(rdy), 32'd1);
    read_chk("row0_col50", 0, 50, 1'b1);
    read_chk("row0_col49", 0, 49, 1'b0);

    // Sequential fill with wrap back to row 0.
    for (int a = 1; a <= ROWS; a++) put_row(a % ROWS, rnd_row());
    wait_rdy("rdy_after_fill");
    for (int r = 0; r < ROWS; r++) begin
      read_model("fill_col0", r, 0);
      read_model("fill_col99", r, COLS - 1);
      for (int k = 0; k < 3; k++) read_model("fill_rand", r, int'($urandom_range(COLS - 1, 0)));
    end
    check("fill_ovf", 32'(ovf_err), 32'(ovf_m));
    check("fill_ovf_zero", 32'(ovf_err), 32'd0);

    // Out-of-range address: flagged, nothing stored, store stays ready.
    put_row(80, rnd_row());
    for (int i = 0; i < 3; i++) begin
      check("oor_rdy", 32'(rdy), 32'd1);
      step();
    end
    check("oor_ovf", 32'(ovf_err), 32'd1);
    for (int r = 0; r < ROWS; r += 7) read_model("oor_nowrite", r, int'($urandom_range(COLS - 1, 0)));

    // Reset 10 cycles into CLEAR, then a second reset; memory must come back all zero.
    d3 = rnd_row();
    d3[7] = 1'b1;
    d4 = ~d3;
    vblank = 1'b0;
    addr_in = 7'd3;
    data_in = d3;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) step();
    check("midclear_init_rdy", 32'(init_rdy), 32'd0);
    check("midclear_ovf", 32'(ovf_err), 32'd0);
    rst = 1'b1;
    step();
    release_and_init(cyc);
    check("reinit_latency", 32'(cyc), 32'd76);
    last_m = 3;
    for (int r = 0; r < ROWS; r++) read_chk("cleared_row", r, int'($urandom_range(COLS - 1, 0)), 1'b0);
    read_chk("oob_row", ROWS, 0, 1'b0);
    read_chk("oob_col", 0, COLS, 1'b0);
    read_chk("oob_both", 127, 127, 1'b0);

    // Address change while pending: row 4 dropped, row 3 still written at vblank.
    addr_in = 7'd4;
    data_in = d4;
    step();
    step();
    check("drop_rdy", 32'(rdy), 32'd0);
    check("drop_ovf", 32'(ovf_err), 32'd1);
    rd_row = 7'd3;
    rd_col = 7'd7;
    step();
    vblank = 1'b1;
    step();
    check("rbw_old_value", 32'(rd_pixel), 32'd0);
    step();
    check("rbw_new_value", 32'(rd_pixel), 32'd1);
    mem_m[3] = d3;
    wait_rdy("rdy_after_drop");
    for (int k = 0; k < 6; k++) begin
      read_model("row3_data", 3, int'($urandom_range(COLS - 1, 0)));
      read_model("row4_clear", 4, int'($urandom_range(COLS - 1, 0)));
    end
    check("final_ovf", 32'(ovf_err), 32'(ovf_m | 1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
